alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single 32-bit ALU between NREQ independent requesters, such as the execute stage and an address/CSR helper unit. Each requester presents an operation through a valid/ready request handshake. The arbiter grants round-robin and registers the operands into the ALU. It captures the ALU result and carry, then returns them to the winning requester through a valid/ready response handshake. The block sits between the requesters and the ALU instance; the ALU stays purely combinational.

Parameters:
NREQ, 2, number of requesters (2..8)
W, 32, operand/result width; must match the ALU width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester request accept (one-hot or zero)
req_op  in  4*NREQ  ALU select code per requester; slice i = [4i+3:4i]
req_a  in  W*NREQ  operand A per requester
req_b  in  W*NREQ  operand B per requester
rsp_valid  out  NREQ  result valid, one-hot to the owner
rsp_ready  in  NREQ  per-requester result accept
rsp_data  out  W  result (shared bus, qualified by rsp_valid)
rsp_cout  out  1  carry/borrow from add/sub; 0 for other ops
alu_a  out  W  to ALU a
alu_b  out  W  to ALU b
alu_s  out  4  to ALU s
alu_e  in  W  from ALU e
alu_cout  in  1  from ALU cout

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock; rst_n clears all state immediately.
- Reset values:
  - state=IDLE, rr_ptr=0, owner=0.
  - Operand regs, rsp_data and rsp_cout are 0.
  - req_ready=0, rsp_valid=0, alu_a/alu_b/alu_s=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid is set, stay in IDLE with req_ready=0.
  - Otherwise select the winner: the first asserted index at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in this cycle only; all other bits stay 0.
  - On the clock edge, capture req_op/a/b[winner] into op_q/a_q/b_q, set owner=winner, and go to EXEC.
- EXEC:
  - alu_a=a_q, alu_b=b_q, alu_s=op_q. These outputs hold op_q-driven values in every state, so the ALU inputs are glitch-free.
  - On the clock edge, rsp_data<=alu_e.
  - rsp_cout<=alu_cout when op_q is 0000 (add) or 1000 (sub); otherwise rsp_cout<=0.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1, held stable together with rsp_data/rsp_cout until rsp_ready[owner]=1.
  - On the handshake edge: rr_ptr<=(owner+1) mod NREQ, then go to IDLE.
  - rsp_ready on non-owner bits is ignored.
- Latency and throughput:
  - Accept edge T produces rsp_valid from cycle T+2, given zero response backpressure.
  - Sustained throughput is 1 op per 3 cycles.
- Boundary conditions:
  - Requests are not accepted while in EXEC or RESP; req_ready=0 in those states.
  - A requester keeps req_valid and its payload stable until accepted.
  - Requests arriving in the same cycle: only the winner is accepted; losers wait.
  - Fairness: a requester waits at most NREQ-1 grants.
  - Unknown op codes pass through unchanged; the ALU returns 0 and rsp_cout=0.
  - Reset mid-operation: the in-flight op is discarded and rsp_valid drops asynchronously. Requesters re-issue after reset.
  - rr_ptr wraps from NREQ-1 to 0.

Optional Feature:
ALU_SHARE_ARBITER_STATS_EN
- Defined: adds output stat_grants [16*NREQ]. It holds one saturating 16-bit counter per requester, incremented on each accept and reset to 0. Counters hold at 16'hFFFF.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t: a 4-bit enum, ADD=0000, SUB=1000, AND=0111, OR=0110, XOR=0100, SLL=0001, SRL=0101, SRA=1101.
  - arb_state_t: IDLE/EXEC/RESP.
  - The constant ALU_W=32.
- Sub-module rr_pick is combinational. Inputs are NREQ request bits and the pointer; outputs are the one-hot grant and its index. It is reusable by other arbiters.

Test Plan:
- Reset: req0 valid with op=0000, a=5, b=7.
  - Accept at T; rsp_valid[0] at T+2 with rsp_data=12, rsp_cout=0.
- Carry/borrow: add a=FFFFFFFF, b=1.
  - rsp_data=0, rsp_cout=1.
  - Then sub a=3, b=5 gives rsp_data=FFFFFFFE with cout as returned by the ALU.
- Round-robin: req0 and req1 both valid continuously, each with op=0110 (OR).
  - Grants alternate 0,1,0,1.
  - rsp_valid is one-hot to the matching owner each time; rr_ptr wraps to 0.
- Backpressure: rsp_ready[1]=0 for 5 cycles, op=1101, a=80000000, b=4.
  - rsp_data=F8000000 is held stable; req_ready stays 0 for both requesters until the handshake.
- Unknown op: op=1111, a=1234, b=1.
  - rsp_data=0, rsp_cout=0; the FSM returns to IDLE normally.
- Async reset while in RESP:
  - rsp_valid drops without waiting for a clock edge.
  - After rst_n rises, a new req1 op=0001, a=1, b=31 yields rsp_data=80000000.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: ALU op codes, arbiter FSM states and shared width for the ALU sharing arbiter
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SLL = 4'b0001,
    XOR = 4'b0100,
    SRL = 4'b0101,
    OR  = 4'b0110,
    AND = 4'b0111,
    SUB = 4'b1000,
    SRA = 4'b1101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // Only add and subtract produce a meaningful carry/borrow.
  function automatic logic has_carry(input logic [3:0] op);
    return op == ADD || op == SUB;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wrapping modulo N
module rr_pick #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Rotate so bit 0 is the pointer position, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) off = IW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters; optional ALU_SHARE_ARBITER_STATS_EN adds per-requester grant counters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W = ALU_W,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_cout,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_s,
  input  logic [W-1:0]      alu_e,
  input  logic              alu_cout
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [16*NREQ-1:0] stat_grants
`endif
);

  arb_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [NREQ-1:0] win_grant;
  logic [IW-1:0]   win_idx;
  logic            win_any;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign req_ready = (state == IDLE) ? win_grant : '0;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_s = op_q;

  // Accept one request, let the ALU settle on registered operands, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= '0;
    end else begin
      case (state)
        IDLE: if (win_any) begin
          op_q  <= req_op[4*win_idx +: 4];
          a_q   <= req_a[W*win_idx +: W];
          b_q   <= req_b[W*win_idx +: W];
          owner <= win_idx;
          state <= EXEC;
        end
        EXEC: begin
          rsp_data  <= alu_e;
          rsp_cout  <= has_carry(op_q) & alu_cout;
          rsp_valid <= NREQ'(1) << owner;
          state     <= RESP;
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid <= '0;
          rr_ptr    <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic accept;

  assign accept = state == IDLE && win_any;

  // Saturating count of accepts per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_grants <= '0;
    else if (accept && stat_grants[16*win_idx +: 16] != 16'hFFFF)
      stat_grants[16*win_idx +: 16] <= stat_grants[16*win_idx +: 16] + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with a transaction-level reference model and a bench-side ALU
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op = '0;
  logic [W*NREQ-1:0] req_a = '0;
  logic [W*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '1;
  logic [W-1:0]      rsp_data;
  logic              rsp_cout;
  logic [W-1:0]      alu_a, alu_b, alu_e;
  logic [3:0]        alu_s;
  logic              alu_cout;
  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_e(alu_e), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Bench ALU: non-arithmetic ops drive a junk carry so the arbiter must mask it.
  function automatic logic [32:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b1000: return {1'b0, a} - {1'b0, b};
      4'b0111: return {^a, a & b};
      4'b0110: return {^a, a | b};
      4'b0100: return {^a, a ^ b};
      4'b0001: return {^a, a << b[4:0]};
      4'b0101: return {^a, a >> b[4:0]};
      4'b1101: return {^a, 32'($signed(a) >>> b[4:0])};
      default: return {^a, 32'h0};
    endcase
  endfunction

  always_comb {alu_cout, alu_e} = alu_f(alu_s, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: one transaction at a time, phase 0 idle, 1 computing, 2 offering the result.
  int m_phase, m_ptr, m_owner, m_win;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always_comb m_win = pick(req_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_ptr <= 0; m_owner <= 0; m_op <= '0; m_a <= '0; m_b <= '0;
    end else if (m_phase == 0) begin
      if (m_win >= 0) begin
        m_owner <= m_win;
        m_op <= req_op[4*m_win +: 4];
        m_a <= req_a[32*m_win +: 32];
        m_b <= req_b[32*m_win +: 32];
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else if (rsp_ready[m_owner]) begin
      m_ptr <= (m_owner + 1) % NREQ;
      m_phase <= 0;
    end
  end

  function automatic logic [32:0] m_res();
    logic [32:0] r;
    r = alu_f(m_op, m_a, m_b);
    return {(m_op == 4'b0000 || m_op == 4'b1000) ? r[32] : 1'b0, r[31:0]};
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", req_ready, (m_phase == 0 && m_win >= 0) ? (1 << m_win) : 0);
      chk("rsp_valid", rsp_valid, (m_phase == 2) ? (1 << m_owner) : 0);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_s", alu_s, m_op);
      if (m_phase == 2) begin
        chk("rsp_data", rsp_data, m_res() & 33'h0FFFFFFFF);
        chk("rsp_cout", rsp_cout, m_res() >> 32);
      end
    end
  end

  task automatic issue(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*r +: 4] = op;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL issue_timeout: requester %0d never accepted", r);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r, input logic [31:0] d, input logic c, input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[r]) begin
        chk({name, "_data"}, rsp_data, d);
        chk({name, "_cout"}, rsp_cout, c);
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s_timeout: no rsp_valid for requester %0d", name, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #8;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_s", alu_s, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 4'b0000, 32'd5, 32'd7);
    @(negedge clk);
    chk("lat_exec_valid", rsp_valid, 2'b00);
    @(negedge clk);
    chk("lat_resp_valid", rsp_valid, 2'b01);
    chk("lat_data", rsp_data, 32'd12);
    chk("lat_cout", rsp_cout, 1'b0);
    @(posedge clk);
    #1;
    issue(0, 4'b0000, 32'hFFFF_FFFF, 32'd1);
    wait_rsp(0, 32'h0, 1'b1, "add_carry");
    issue(1, 4'b1000, 32'd3, 32'd5);
    wait_rsp(1, 32'hFFFF_FFFE, 1'b1, "sub_borrow");
    req_op = {4'b0110, 4'b0110};
    req_a = {32'h100, 32'hF0};
    req_b = {32'h1, 32'h0F};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int e;
      bit seen;
      e = g % 2;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = req_ready != 0;
      end
      chk("rr_grant", req_ready, 1 << e);
      if (g == 3) begin
        @(posedge clk);
        #1 req_valid = 2'b00;
      end
      wait_rsp(e, e ? 32'h101 : 32'hFF, 1'b0, "rr_rsp");
    end
    req_op = {4'b0001, 4'b1111};
    req_a = {32'd1, 32'h1234};
    req_b = {32'd3, 32'd1};
    req_valid = 2'b11;
    @(negedge clk);
    chk("rr_wrap_grant", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(0, 32'h0, 1'b0, "unknown_op");
    issue(1, 4'b0001, 32'd1, 32'd3);
    wait_rsp(1, 32'h8, 1'b0, "sll");
    rsp_ready[1] = 1'b0;
    issue(1, 4'b1101, 32'h8000_0000, 32'd4);
    req_op[3:0] = 4'b0100;
    req_a[31:0] = 32'hFF00;
    req_b[31:0] = 32'h0FF0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 20 && !rsp_valid[1]; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", rsp_data, 32'hF800_0000);
      chk("bp_valid", rsp_valid, 2'b10);
      chk("bp_ready", req_ready, 2'b00);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 4'b0100, 32'hFF00, 32'h0FF0);
    wait_rsp(0, 32'hF0F0, 1'b0, "bp_next");
    rsp_ready[0] = 1'b0;
    issue(0, 4'b0000, 32'd2, 32'd3);
    for (int i = 0; i < 20 && !rsp_valid[0]; i++) @(negedge clk);
    chk("pre_rst_valid", rsp_valid, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 2'b00);
    chk("async_rst_data", rsp_data, 32'h0);
    chk("async_rst_alu_a", alu_a, 32'h0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 4'b0001, 32'd1, 32'd31);
    wait_rsp(1, 32'h8000_0000, 1'b0, "post_rst");
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
